// File: rtl/hex_display_scan.sv
// Time-multiplexed scan driver for a 4-digit common-anode hex display.
// Latches one shadow nibble per slot and drives its active-low anode after a ghost-blanking gap.
module hex_display_scan #(
  parameter int DIV   = 100000,
  parameter int GHOST = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  bus_out,
  output logic [3:0]  anodes,
  output logic        slot_tick
);

  localparam int             CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  // r_cnt is the prescaler phase of the upcoming edge; 0 marks a slot start.
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;
  logic [15:0]   r_shadow;
  logic          r_visible;
  logic [3:0]    r_bus;
  logic [3:0]    r_anodes;
  logic          r_tick;

  logic          w_slot_start;
  logic          w_wrap;
  logic [3:0]    w_nibble;
  logic          w_upper_zero;
  logic          w_vis_new;
  logic          w_vis;
  logic          w_in_ghost;
  logic [3:0]    w_anodes_n;
  logic [3:0]    w_bus_n;
  logic [CW-1:0] w_cnt_n;
  logic [1:0]    w_digit_n;

  always_comb begin
    w_nibble     = 4'h0;
    w_upper_zero = 1'b0;
    case (r_digit)
      2'd0: begin w_nibble = r_shadow[3:0];   w_upper_zero = 1'b0;                    end
      2'd1: begin w_nibble = r_shadow[7:4];   w_upper_zero = (r_shadow[15:4]  == '0); end
      2'd2: begin w_nibble = r_shadow[11:8];  w_upper_zero = (r_shadow[15:8]  == '0); end
      default: begin w_nibble = r_shadow[15:12]; w_upper_zero = (r_shadow[15:12] == '0); end
    endcase
  end

  always_comb begin
    w_slot_start = (r_cnt == '0);
    w_wrap       = (r_cnt == LAST);
    w_vis_new    = digit_en[r_digit] && !(lz_blank && w_upper_zero);
    w_vis        = w_slot_start ? w_vis_new : r_visible;
    // Slot edge number is r_cnt+1, so edges 1..GHOST correspond to r_cnt < GHOST.
    w_in_ghost   = (32'(r_cnt) < GHOST);
    w_anodes_n   = (w_in_ghost || !w_vis) ? 4'hF : ~(4'b0001 << r_digit);
    w_bus_n      = w_slot_start ? w_nibble : r_bus;
    w_cnt_n      = w_wrap ? '0 : r_cnt + 1'b1;
    w_digit_n    = w_wrap ? r_digit + 2'd1 : r_digit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_digit   <= 2'd0;
      r_shadow  <= 16'h0000;
      r_visible <= 1'b0;
      r_bus     <= 4'h0;
      r_anodes  <= 4'hF;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_n;
      r_digit   <= w_digit_n;
      r_visible <= w_vis;
      r_bus     <= w_bus_n;
      r_anodes  <= w_anodes_n;
      r_tick    <= w_slot_start;
      if (load) r_shadow <= value_in;
    end
  end

  assign bus_out   = r_bus;
  assign anodes    = r_anodes;
  assign slot_tick = r_tick;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed plus randomized checks of hex_display_scan against a slot-arithmetic reference model.
module tb_hex_display_scan;

  localparam int DIV   = 8;
  localparam int GHOST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  bus_out;
  logic [3:0]  anodes;
  logic        slot_tick;

  hex_display_scan #(.DIV(DIV), .GHOST(GHOST)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load),
    .digit_en(digit_en), .lz_blank(lz_blank),
    .bus_out(bus_out), .anodes(anodes), .slot_tick(slot_tick)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: edge count since reset release gives slot and position directly.
  int          m_n = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [3:0]  m_bus = 4'h0;
  logic        m_vis = 1'b0;
  logic [3:0]  m_an = 4'hF;
  logic        m_tick = 1'b0;
  logic [3:0]  exp_q[$];

  task automatic model_edge();
    int pos, d;
    if (reset) begin
      m_n = 0; m_shadow = 16'h0; m_bus = 4'h0; m_vis = 1'b0; m_an = 4'hF; m_tick = 1'b0;
      exp_q.delete();
    end else begin
      m_n++;
      pos = (m_n - 1) % DIV + 1;
      d   = ((m_n - 1) / DIV) % 4;
      if (pos == 1) begin
        m_bus = m_shadow[4*d +: 4];
        m_vis = digit_en[d] && !(lz_blank && d > 0 && (m_shadow >> (4*d)) == 16'h0);
        exp_q.push_back(m_bus);
      end
      m_tick = (pos == 1);
      m_an   = (pos <= GHOST || !m_vis) ? 4'hF : ~(4'b0001 << d);
      if (load) m_shadow = value_in;
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: per-cycle model compare plus per-slot nibble queue popped on slot_tick.
  task automatic check();
    logic [3:0] q_exp;
    chk4("bus_out", bus_out, m_bus);
    chk4("anodes", anodes, m_an);
    chk4("slot_tick", {3'b0, slot_tick}, {3'b0, m_tick});
    chk4("one_anode_low", {3'b0, ($countones(~anodes) <= 1)}, 4'h1);
    if (slot_tick === 1'b1) begin
      q_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      chk4("slot_nibble_q", bus_out, q_exp);
    end
  endtask

  // Driver tasks: inputs are changed 1 time unit after an edge, outputs sampled there too.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check();
  endtask

  task automatic load_slot(input logic [15:0] v);
    load = 1'b1; value_in = v;
    step();
    load = 1'b0;
    repeat (DIV - 1) step();
  endtask

  task automatic run_slot(input logic [3:0] nib, input logic [3:0] an);
    for (int p = 1; p <= DIV; p++) begin
      step();
      if (p == 1) begin
        chk4("slot_start_bus", bus_out, nib);
        chk4("slot_start_tick", {3'b0, slot_tick}, 4'h1);
      end
      if (p == DIV) chk4("slot_end_anodes", anodes, an);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b1; value_in = 16'hFFFF; digit_en = 4'hF; lz_blank = 1'b0;

    // Reset held for three edges with a pending load
    for (int i = 0; i < 3; i++) begin
      step();
      chk4("rst_anodes", anodes, 4'hF);
      chk4("rst_bus", bus_out, 4'h0);
      chk4("rst_tick", {3'b0, slot_tick}, 4'h0);
    end

    // Release; slot 0 latches the cleared shadow while 12AF is captured
    reset = 1'b0; load = 1'b1; value_in = 16'h12AF;
    step();
    chk4("rel_bus", bus_out, 4'h0);
    chk4("rel_tick", {3'b0, slot_tick}, 4'h1);
    load = 1'b0;
    repeat (DIV - 1) step();

    // Basic scan (slots 1..4)
    run_slot(4'hA, 4'b1101);
    run_slot(4'h2, 4'b1011);
    run_slot(4'h1, 4'b0111);
    run_slot(4'hF, 4'b1110);

    // Leading-zero blanking
    lz_blank = 1'b1;
    load_slot(16'h0005);           // slot 5, digit 1
    run_slot(4'h0, 4'hF);          // digit 2
    run_slot(4'h0, 4'hF);          // digit 3
    run_slot(4'h5, 4'b1110);       // digit 0
    run_slot(4'h0, 4'hF);          // digit 1
    load_slot(16'h0000);           // slot 10, digit 2
    run_slot(4'h0, 4'hF);          // digit 3
    run_slot(4'h0, 4'b1110);       // digit 0 still lit
    run_slot(4'h0, 4'hF);          // digit 1
    load_slot(16'h0300);           // slot 14, digit 2
    run_slot(4'h0, 4'hF);          // digit 3 dark
    run_slot(4'h0, 4'b1110);       // digit 0
    run_slot(4'h0, 4'b1101);       // digit 1
    run_slot(4'h3, 4'b1011);       // digit 2
    lz_blank = 1'b0;

    // Mid-slot load while digit 0 shows F
    load_slot(16'h12AF);           // slot 19, digit 3
    repeat (3) step();             // slot 20 edges 1..3
    load = 1'b1; value_in = 16'h1234;
    step();                        // slot edge 4
    load = 1'b0;
    repeat (4) step();
    chk4("midload_hold", bus_out, 4'hF);
    run_slot(4'h3, 4'b1101);
    run_slot(4'h2, 4'b1011);
    run_slot(4'h1, 4'b0111);
    run_slot(4'h4, 4'b1110);

    // Enable mask 0101
    digit_en = 4'b0101;
    run_slot(4'h3, 4'hF);
    run_slot(4'h2, 4'b1011);
    run_slot(4'h1, 4'hF);
    run_slot(4'h4, 4'b1110);
    digit_en = 4'hF;

    // Reset during an active slot (digit 1)
    repeat (5) step();
    chk4("pre_reset_anodes", anodes, 4'b1101);
    reset = 1'b1;
    step();
    chk4("midrst_anodes", anodes, 4'hF);
    chk4("midrst_bus", bus_out, 4'h0);
    chk4("midrst_tick", {3'b0, slot_tick}, 4'h0);
    reset = 1'b0;
    run_slot(4'h0, 4'b1110);
    run_slot(4'h0, 4'b1101);
    run_slot(4'h0, 4'b1011);
    run_slot(4'h0, 4'b0111);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 9) == 0);
      value_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value_in = value_in & 16'h00FF;
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
